edge_pulse_stretcher: RTL and testbench
=======================================

# edge_pulse_stretcher

Multi-channel, parametrised edge detector that supersedes the single-mode trailing-edge pulse generator. Each channel synchronises an asynchronous level, detects rising, falling or both edges (runtime-selectable), emits a one-cycle pulse, stretches it to a programmable length and records it in a clearable sticky flag. Sits between external/async status lines and the control-register / interrupt logic.

## Interface

- WIDTH, 8, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (0 = input already synchronous, max 3)
- STRETCH_W, 4, width of per-channel stretch counter
- clk  in  1  single clock; all state on rising edge
- ares_n  in  1  reset, asynchronous, active-low
- sres  in  1  synchronous clear, active-high; same effect as reset
- ld_en  in  1  sample enable; when low, delay register and counters hold and no edges detected
- mode  in  2  00 off, 01 rising, 10 falling, 11 both; shared by all channels
- stretch_len  in  STRETCH_W  stretched pulse length in cycles; 0 treated as 1
- level_in  in  WIDTH  raw level inputs
- event_clr  in  WIDTH  per-channel sticky clear, one-cycle strobe
- pulse_out  out  WIDTH  registered one-cycle edge pulse
- stretch_out  out  WIDTH  stretched pulse
- event_sticky  out  WIDTH  latched edge flag
- any_event  out  1  registered OR of event_sticky

## Operation

- Sync chain: level_in through SYNC_STAGES flops -> s; runs every cycle regardless of ld_en.
- Delay reg d and per-channel armed bit update only when ld_en=1: d <= s, armed <= 1.
- Edge (combinational): rise = s & ~d, fall = ~s & d; edge = ld_en & armed & ((mode[0] & rise) | (mode[1] & fall)).
- First ld_en sample after reset/sres only loads d and sets armed; no edge, so a level already high at reset release does not fire.
- pulse_out <= edge.
- Stretch counter cnt: on edge, cnt <= max(stretch_len,1); else if ld_en & cnt!=0, cnt <= cnt-1. stretch_out = (cnt != 0), driven from flop. Edge while cnt!=0 reloads (retrigger, no accumulation).
- Sticky: set on edge, cleared by event_clr; set and clear same cycle -> set wins.
- any_event <= |event_sticky (next-state value, so tracks event_sticky same cycle).
- mode change takes effect the next cycle; mode=00 suppresses new edges but running stretches and sticky bits persist.

## Timing

- Reset (ares_n=0 or sres=1): sync chain, d, armed, cnt, pulse_out, stretch_out, event_sticky, any_event all 0.
- ares_n is asynchronous assert; deassertion assumed synchronised upstream.
- Latency level_in change -> pulse_out high: SYNC_STAGES+1 cycles (ld_en held high, armed).
- stretch_out rises same cycle as pulse_out; stays high exactly max(stretch_len,1) cycles with ld_en=1; while ld_en=0 it freezes.
- event_sticky rises same cycle as pulse_out; clears the cycle after event_clr.
- Input pulse shorter than one cycle after synchronisation may be missed; no requirement.
- Change of s while ld_en=0 is detected at the next ld_en=1 cycle only if s still differs from d.

## Structure

- Shared package edge_pkg: mode encodings MODE_OFF/RISE/FALL/BOTH, max SYNC_STAGES constant.
- Sub-module edge_stretch_channel: one channel (sync, delay, armed, counter, sticky); top is a generate loop over WIDTH plus any_event reduction.

## Test plan

- Reset, WIDTH=8, SYNC_STAGES=2, mode=01, stretch_len=3; level_in[0] 0->1 -> pulse_out[0] high 1 cycle at +3, stretch_out[0] high 3 cycles, event_sticky[0]=1, any_event=1.
- level_in[5] held 1 through reset release -> no pulse; then 1->0 with mode=10 -> pulse at +3.
- mode=11, level_in[2] toggles every 8 cycles -> pulse on every toggle; mode=00 -> no pulses, sticky retained.
- Retrigger: stretch_len=5, second edge 2 cycles after first -> stretch_out continuous 7 cycles; stretch_len=0 -> 1-cycle stretch.
- event_clr[0] coincident with new edge on channel 0 -> sticky stays 1; event_clr alone -> 0 next cycle, any_event 0.
- ares_n pulled low mid-stretch -> all outputs 0 immediately; ld_en=0 during stretch -> stretch_out frozen, resumes count when ld_en=1.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge pulse stretcher: edge-mode encodings and parameter limits.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: none; nothing in this package holds state.
package edge_pkg;

   // Edge select, shared by every channel. Bit 0 enables rising edges, bit 1 enables falling edges.
   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_t;

   // Deepest synchroniser supported. Zero stages means the input is already in the clk domain.
   localparam int MAX_SYNC_STAGES = 3;

   // Widest channel count supported by one instance.
   localparam int MAX_WIDTH = 32;

   // True when the selected mode accepts the observed edge.
   function automatic logic mode_hit(input mode_t m, input logic rise, input logic fall);
      return (m[0] & rise) | (m[1] & fall);
   endfunction

endpackage

// File: rtl/edge_pulse_stretcher_if.sv
// Control and status bundle between the edge pulse stretcher and its register/interrupt client.
// Latency: n/a (wiring only).
// Backpressure: none; every output is a level or a pulse and nothing is handshaken.
// Ports:
//   ld_en        sample enable; low freezes edge detection and stretch counters
//   mode         edge select, shared by all channels
//   stretch_len  stretched pulse length in cycles, 0 behaves as 1
//   level_in     raw, possibly asynchronous, level inputs
//   event_clr    per-channel one-cycle sticky clear
//   pulse_out    one-cycle registered edge pulse per channel
//   stretch_out  stretched edge pulse per channel
//   event_sticky latched edge flag per channel
//   any_event    registered OR of event_sticky
interface edge_pulse_stretcher_if
   import edge_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int STRETCH_W = 4
);

   logic                 ld_en;
   mode_t                mode;
   logic [STRETCH_W-1:0] stretch_len;
   logic [WIDTH-1:0]     level_in;
   logic [WIDTH-1:0]     event_clr;
   logic [WIDTH-1:0]     pulse_out;
   logic [WIDTH-1:0]     stretch_out;
   logic [WIDTH-1:0]     event_sticky;
   logic                 any_event;

   // Client side: programs the block and consumes its event outputs.
   modport master (
      output ld_en,
      output mode,
      output stretch_len,
      output level_in,
      output event_clr,
      input  pulse_out,
      input  stretch_out,
      input  event_sticky,
      input  any_event
   );

   // Block side.
   modport slave (
      input  ld_en,
      input  mode,
      input  stretch_len,
      input  level_in,
      input  event_clr,
      output pulse_out,
      output stretch_out,
      output event_sticky,
      output any_event
   );

endinterface

// File: rtl/edge_stretch_channel.sv
// One channel: synchroniser, delay register, edge detect, stretch counter and sticky flag.
// Latency: level change to pulse is SYNC_STAGES+1 cycles with ld_en high and the channel armed.
// Backpressure: none; ld_en low freezes the delay register and counter, the synchroniser keeps running.
// Ports:
//   clk, ares_n, sres   clock, async active-low reset, sync active-high clear
//   ld_en, mode         sample enable and edge select (shared by all channels)
//   stretch_len         stretch length, 0 behaves as 1
//   level, clr          raw level input and sticky clear strobe
//   pulse, stretch      registered one-cycle pulse and registered stretched pulse
//   sticky, sticky_nxt  sticky flag and its next-state value (feeds the top-level OR)
module edge_stretch_channel
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH_W   = 4
) (
   input  logic                 clk,
   input  logic                 ares_n,
   input  logic                 sres,
   input  logic                 ld_en,
   input  mode_t                mode,
   input  logic [STRETCH_W-1:0] stretch_len,
   input  logic                 level,
   input  logic                 clr,
   output logic                 pulse,
   output logic                 stretch,
   output logic                 sticky,
   output logic                 sticky_nxt
);

   logic                 s;        // synchronised level
   logic                 d;        // level seen at the previous enabled sample
   logic                 armed;    // d holds a real sample, so s vs d is meaningful
   logic                 rise;
   logic                 fall;
   logic                 hit;
   logic [STRETCH_W-1:0] load_val;
   logic [STRETCH_W-1:0] cnt;
   logic [STRETCH_W-1:0] cnt_nxt;

   // Synchroniser: free-running so s always reflects the current input,
   // even while ld_en is low.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = level;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         always_ff @(posedge clk or negedge ares_n) begin
            if (!ares_n) begin
               sync_q <= '0;
            end else if (sres) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= level;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_comb begin
      rise       = 1'b0;
      fall       = 1'b0;
      hit        = 1'b0;
      load_val   = stretch_len;
      cnt_nxt    = cnt;
      sticky_nxt = 1'b0;

      rise = s & ~d;
      fall = ~s & d;
      // armed gates the first enabled sample after reset: that sample only
      // loads d, so a line already high at reset release never fires.
      hit  = ld_en & armed & mode_hit(mode, rise, fall);

      if (stretch_len == '0) begin
         load_val = STRETCH_W'(1);
      end

      // A new edge reloads the counter outright; retriggers extend, never accumulate.
      if (hit) begin
         cnt_nxt = load_val;
      end else if (ld_en && (cnt != '0)) begin
         cnt_nxt = cnt - STRETCH_W'(1);
      end

      // Set wins over a coincident clear so an edge is never lost.
      sticky_nxt = hit | (sticky & ~clr);
   end

   always_ff @(posedge clk or negedge ares_n) begin
      if (!ares_n) begin
         d       <= 1'b0;
         armed   <= 1'b0;
         pulse   <= 1'b0;
         cnt     <= '0;
         stretch <= 1'b0;
         sticky  <= 1'b0;
      end else if (sres) begin
         d       <= 1'b0;
         armed   <= 1'b0;
         pulse   <= 1'b0;
         cnt     <= '0;
         stretch <= 1'b0;
         sticky  <= 1'b0;
      end else begin
         if (ld_en) begin
            d     <= s;
            armed <= 1'b1;
         end
         pulse   <= hit;
         cnt     <= cnt_nxt;
         // Registered from the next count so stretch rises with pulse and
         // comes straight off a flop.
         stretch <= (cnt_nxt != '0);
         sticky  <= sticky_nxt;
      end
   end

endmodule

// File: rtl/edge_pulse_stretcher.sv
// Multi-channel edge detector with runtime edge select, programmable pulse stretch and clearable sticky flags.
// Latency: level change to pulse_out/stretch_out/event_sticky is SYNC_STAGES+1 cycles; any_event tracks event_sticky in the same cycle.
// Backpressure: none; ld_en low freezes edge detection and stretch counting but not the synchronisers.
// Ports:
//   clk     single clock, all state on the rising edge
//   ares_n  asynchronous active-low reset (deassertion synchronised upstream)
//   sres    synchronous active-high clear, same effect as reset
//   bus     slave side of edge_pulse_stretcher_if (controls, levels, event outputs)
module edge_pulse_stretcher
   import edge_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH_W   = 4
) (
   input logic                    clk,
   input logic                    ares_n,
   input logic                    sres,
   edge_pulse_stretcher_if.slave  bus
);

   // Reject unsupported configurations at elaboration instead of building
   // something silently different.
   generate
      if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
         $error("edge_pulse_stretcher: WIDTH must be 1..32");
      end
      if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
         $error("edge_pulse_stretcher: SYNC_STAGES must be 0..3");
      end
      if (STRETCH_W < 1) begin : g_bad_stretch
         $error("edge_pulse_stretcher: STRETCH_W must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0] pulse_v;
   logic [WIDTH-1:0] stretch_v;
   logic [WIDTH-1:0] sticky_v;
   logic [WIDTH-1:0] sticky_nxt_v;
   logic             any_q;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_ch
         edge_stretch_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .STRETCH_W   (STRETCH_W)
         ) u_ch (
            .clk         (clk),
            .ares_n      (ares_n),
            .sres        (sres),
            .ld_en       (bus.ld_en),
            .mode        (bus.mode),
            .stretch_len (bus.stretch_len),
            .level       (bus.level_in[i]),
            .clr         (bus.event_clr[i]),
            .pulse       (pulse_v[i]),
            .stretch     (stretch_v[i]),
            .sticky      (sticky_v[i]),
            .sticky_nxt  (sticky_nxt_v[i])
         );
      end
   endgenerate

   // Built from the next-state sticky bits so the summary flag moves in the
   // same cycle as event_sticky rather than one behind.
   always_ff @(posedge clk or negedge ares_n) begin
      if (!ares_n) begin
         any_q <= 1'b0;
      end else if (sres) begin
         any_q <= 1'b0;
      end else begin
         any_q <= |sticky_nxt_v;
      end
   end

   assign bus.pulse_out    = pulse_v;
   assign bus.stretch_out  = stretch_v;
   assign bus.event_sticky = sticky_v;
   assign bus.any_event    = any_q;

endmodule

// File: tb/tb_edge_pulse_stretcher.sv
module tb_edge_pulse_stretcher;
   import edge_pkg::*;

   typedef struct {
      logic       ld;
      mode_t      mode;
      logic [3:0] len;
      logic [7:0] lvl;
      logic [7:0] clr;
      logic [7:0] e_pulse;
      logic [7:0] e_str;
      logic [7:0] e_sticky;
      logic       e_any;
   } vec_t;

   logic clk;
   logic ares_n;
   logic sres;
   int   errors;
   int   checks;
   vec_t vecs[$];
   logic [7:0] lvl;

   edge_pulse_stretcher_if #(.WIDTH(8), .STRETCH_W(4)) bus ();

   edge_pulse_stretcher #(
      .WIDTH       (8),
      .SYNC_STAGES (2),
      .STRETCH_W   (4)
   ) dut (
      .clk    (clk),
      .ares_n (ares_n),
      .sres   (sres),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic ld, input mode_t m, input logic [3:0] len,
                      input logic [7:0] lv, input logic [7:0] cl,
                      input logic [7:0] ep, input logic [7:0] es,
                      input logic [7:0] est, input logic ea);
      vec_t v;
      v.ld = ld; v.mode = m; v.len = len; v.lvl = lv; v.clr = cl;
      v.e_pulse = ep; v.e_str = es; v.e_sticky = est; v.e_any = ea;
      vecs.push_back(v);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " pulse"},   32'(bus.pulse_out),    32'h0);
      chk({nm, " stretch"}, 32'(bus.stretch_out),  32'h0);
      chk({nm, " sticky"},  32'(bus.event_sticky), 32'h0);
      chk({nm, " any"},     32'(bus.any_event),    32'h0);
   endtask

   initial begin
      int ns;
      int np;
      int nr;
      int nb;
      logic prev;
      errors = 0;
      checks = 0;

      // Per-cycle vectors: inputs applied before a rising edge, outputs expected after it.
      // Start-up with ch5 high through reset, ld_en low while the synchroniser fills.
      add(0, MODE_RISE, 3, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      add(0, MODE_RISE, 3, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      add(1, MODE_RISE, 3, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 0);  // arm only, no edge
      // ch0 rises: pulse at +3, stretch 3 cycles.
      add(1, MODE_RISE, 3, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      add(1, MODE_RISE, 3, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      add(1, MODE_RISE, 3, 8'h21, 8'h00, 8'h01, 8'h01, 8'h01, 1);
      add(1, MODE_RISE, 3, 8'h21, 8'h00, 8'h00, 8'h01, 8'h01, 1);
      add(1, MODE_RISE, 3, 8'h21, 8'h00, 8'h00, 8'h01, 8'h01, 1);
      add(1, MODE_RISE, 3, 8'h21, 8'h00, 8'h00, 8'h00, 8'h01, 1);
      // ch5 falls under falling mode.
      add(1, MODE_FALL, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1);
      add(1, MODE_FALL, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1);
      add(1, MODE_FALL, 3, 8'h01, 8'h00, 8'h20, 8'h20, 8'h21, 1);
      add(1, MODE_FALL, 3, 8'h01, 8'h00, 8'h00, 8'h20, 8'h21, 1);
      add(1, MODE_FALL, 3, 8'h01, 8'h00, 8'h00, 8'h20, 8'h21, 1);
      add(1, MODE_FALL, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h21, 1);
      // Clear both sticky bits, any_event follows in the same cycle.
      add(1, MODE_FALL, 3, 8'h01, 8'h21, 8'h00, 8'h00, 8'h00, 0);
      // Both-edge mode: ch2 up then down, each edge fires.
      add(1, MODE_BOTH, 3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      add(1, MODE_BOTH, 3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      add(1, MODE_BOTH, 3, 8'h05, 8'h00, 8'h04, 8'h04, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h05, 8'h00, 8'h00, 8'h04, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h05, 8'h00, 8'h00, 8'h04, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h01, 8'h00, 8'h04, 8'h04, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h01, 8'h00, 8'h00, 8'h04, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h01, 8'h00, 8'h00, 8'h04, 8'h04, 1);
      add(1, MODE_BOTH, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 1);
      // Mode off: ch2 rises again, no pulse, sticky retained.
      add(1, MODE_OFF,  3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 1);
      add(1, MODE_OFF,  3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 1);
      add(1, MODE_OFF,  3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 1);
      add(1, MODE_OFF,  3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 1);

      // Reset with ch5 already high.
      ares_n = 1'b0;
      sres   = 1'b0;
      bus.ld_en       = 1'b0;
      bus.mode        = MODE_RISE;
      bus.stretch_len = 4'd3;
      bus.level_in    = 8'h20;
      bus.event_clr   = 8'h00;
      repeat (3) tick();
      chk_all_zero("reset");
      ares_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.ld_en       = vecs[i].ld;
         bus.mode        = vecs[i].mode;
         bus.stretch_len = vecs[i].len;
         bus.level_in    = vecs[i].lvl;
         bus.event_clr   = vecs[i].clr;
         tick();
         chk($sformatf("row%0d pulse", i),   32'(bus.pulse_out),    32'(vecs[i].e_pulse));
         chk($sformatf("row%0d stretch", i), 32'(bus.stretch_out),  32'(vecs[i].e_str));
         chk($sformatf("row%0d sticky", i),  32'(bus.event_sticky), 32'(vecs[i].e_sticky));
         chk($sformatf("row%0d any", i),     32'(bus.any_event),    32'(vecs[i].e_any));
      end
      bus.event_clr = 8'h00;
      lvl = 8'h05;

      // Retrigger on ch3: len 5, second edge two cycles after the first -> one 7-cycle stretch.
      bus.mode = MODE_BOTH;
      bus.stretch_len = 4'd5;
      ns = 0; np = 0; nr = 0; prev = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (k == 0) lvl = 8'h0D;
         if (k == 2) lvl = 8'h05;
         bus.level_in = lvl;
         tick();
         ns += int'(bus.stretch_out[3]);
         np += int'(bus.pulse_out[3]);
         if (bus.stretch_out[3] && !prev) nr++;
         prev = bus.stretch_out[3];
      end
      chk("retrig stretch cycles", 32'(ns), 32'd7);
      chk("retrig pulses", 32'(np), 32'd2);
      chk("retrig single run", 32'(nr), 32'd1);

      // stretch_len 0 behaves as 1 on ch4.
      bus.stretch_len = 4'd0;
      lvl = 8'h15;
      bus.level_in = lvl;
      ns = 0; nb = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         ns += int'(bus.stretch_out[4]);
         nb += int'(bus.stretch_out[4] & bus.pulse_out[4]);
      end
      chk("len0 stretch cycles", 32'(ns), 32'd1);
      chk("len0 aligned with pulse", 32'(nb), 32'd1);

      // Sticky clear alone, then clear coincident with a new edge on ch0.
      bus.stretch_len = 4'd3;
      lvl = 8'h14;
      bus.level_in = lvl;
      repeat (3) tick();
      chk("ch0 fall sticky", 32'(bus.event_sticky[0]), 32'd1);
      bus.event_clr = 8'h01;
      tick();
      chk("clr alone sticky", 32'(bus.event_sticky[0]), 32'd0);
      bus.event_clr = 8'h00;
      lvl = 8'h15;
      bus.level_in = lvl;
      tick();
      tick();
      chk("pre-edge sticky", 32'(bus.event_sticky[0]), 32'd0);
      bus.event_clr = 8'h01;
      tick();
      chk("set+clr pulse", 32'(bus.pulse_out[0]), 32'd1);
      chk("set+clr sticky", 32'(bus.event_sticky[0]), 32'd1);
      bus.event_clr = 8'hFF;
      tick();
      chk("clr all sticky", 32'(bus.event_sticky), 32'h0);
      chk("clr all any", 32'(bus.any_event), 32'd0);
      bus.event_clr = 8'h00;

      // ld_en low mid-stretch on ch6 freezes the counter.
      bus.stretch_len = 4'd4;
      lvl = 8'h55;
      bus.level_in = lvl;
      repeat (3) tick();
      chk("freeze start stretch", 32'(bus.stretch_out[6]), 32'd1);
      bus.ld_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("frozen%0d stretch", k), 32'(bus.stretch_out[6]), 32'd1);
      end
      bus.ld_en = 1'b1;
      ns = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         ns += int'(bus.stretch_out[6]);
      end
      chk("resume stretch cycles", 32'(ns), 32'd3);
      chk("resume end stretch", 32'(bus.stretch_out[6]), 32'd0);

      // Synchronous clear, then re-arm without spurious pulses.
      chk("pre-sres sticky", 32'(bus.event_sticky), 32'h40);
      sres = 1'b1;
      tick();
      chk_all_zero("sres");
      sres = 1'b0;
      bus.ld_en = 1'b0;
      np = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 2) bus.ld_en = 1'b1;
         tick();
         np += int'(|bus.pulse_out);
      end
      chk("post-sres pulses", 32'(np), 32'd0);

      // Asynchronous reset mid-stretch on ch7.
      bus.stretch_len = 4'd5;
      lvl = 8'hD5;
      bus.level_in = lvl;
      repeat (3) tick();
      chk("pre-ares stretch", 32'(bus.stretch_out), 32'h80);
      ares_n = 1'b0;
      #1;
      chk_all_zero("ares");
      #2;
      ares_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
